// File: rtl/ccff_chain_loader_if.sv
// ---------------------------------------------------------------------------
// ccff_chain_loader_if
//   Word handshake between a bitstream source and the chain loader.
//   cfg_data  : configuration word, bit 0 is shifted into the chain first
//   cfg_valid : source has a word on cfg_data
//   cfg_ready : loader takes the word on this cycle
//   master = bitstream source, slave = loader
// ---------------------------------------------------------------------------
interface ccff_chain_loader_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;

    modport master (output cfg_data, output cfg_valid, input cfg_ready);
    modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/ccff_chain_loader.sv
// ---------------------------------------------------------------------------
// ccff_chain_loader
//   Loads a configuration flop chain (ccff_head -> ccff_tail) from a stream
//   of words, LSB first, shifting exactly CHAIN_LEN bits per load. The parity
//   of the old chain contents emerging at ccff_tail is accumulated.
//
//   prog_clk    : clock, all state on rising edge
//   pReset      : asynchronous active-low reset
//   start       : begin a load (honoured in IDLE, DONE, ERROR)
//   abort       : return to IDLE from any state, beats start
//   cfg         : word handshake (slave side)
//   ccff_head   : serial data into the chain
//   ccff_tail   : serial data out of the chain
//   chain_en    : shift enable / prog_clk gate enable for the chain
//   busy        : load in progress (FETCH or SHIFT)
//   done / err  : load completed / stalled source
//   tail_parity : XOR of all ccff_tail samples of the current or last load
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | waiting for start
//   FETCH  | cfg_ready high, waiting for a word; stall timer running
//   SHIFT  | one bit per cycle onto ccff_head, chain enabled
//   DONE   | CHAIN_LEN bits shifted, tail_parity valid
//   ERROR  | source stalled STALL_MAX cycles; chain contents undefined
// ---------------------------------------------------------------------------
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 32,
    parameter int WORD_W    = 8,
    parameter int STALL_MAX = 16
) (
    input  logic                prog_clk,
    input  logic                pReset,
    input  logic                start,
    input  logic                abort,
    ccff_chain_loader_if.slave  cfg,
    output logic                ccff_head,
    input  logic                ccff_tail,
    output logic                chain_en,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                tail_parity
);

    localparam int BC_W = $clog2(CHAIN_LEN + 1);
    localparam int SC_W = $clog2(STALL_MAX + 1);
    localparam int WL_W = $clog2(WORD_W + 1);

    localparam logic [BC_W-1:0] CHAIN_LEN_C = BC_W'(CHAIN_LEN);
    localparam logic [BC_W-1:0] LAST_BIT    = BC_W'(CHAIN_LEN - 1);
    localparam logic [SC_W-1:0] STALL_LAST  = SC_W'(STALL_MAX - 1);
    localparam logic [WL_W-1:0] WORD_W_C    = WL_W'(WORD_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [SC_W-1:0]   stall_q, stall_d;
    logic [WL_W-1:0]   word_left_q, word_left_d;
    logic              parity_q, parity_d;

    logic [BC_W-1:0]   bits_left;
    logic [WL_W-1:0]   word_left_init;

    // Last word of a load may be partial: shift only what the chain still needs.
    assign bits_left      = CHAIN_LEN_C - bit_cnt_q;
    assign word_left_init = (int'(bits_left) >= WORD_W) ? WORD_W_C : WL_W'(bits_left);

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            stall_q     <= '0;
            word_left_q <= '0;
            parity_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            stall_q     <= stall_d;
            word_left_q <= word_left_d;
            parity_q    <= parity_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        stall_d     = stall_q;
        word_left_d = word_left_q;
        parity_d    = parity_q;

        if (abort) begin
            // tail_parity deliberately kept so a partial load can still be inspected
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            stall_d   = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state_d   = S_FETCH;
                        bit_cnt_d = '0;
                        stall_d   = '0;
                        parity_d  = 1'b0;
                    end
                end
                S_FETCH: begin
                    if (cfg.cfg_valid) begin
                        shreg_d     = cfg.cfg_data;
                        word_left_d = word_left_init;
                        stall_d     = '0;
                        state_d     = S_SHIFT;
                    end else begin
                        stall_d = stall_q + 1'b1;
                        if (stall_q == STALL_LAST) begin
                            state_d = S_ERROR;
                        end
                    end
                end
                S_SHIFT: begin
                    shreg_d     = shreg_q >> 1;
                    bit_cnt_d   = bit_cnt_q + 1'b1;
                    word_left_d = word_left_q - 1'b1;
                    parity_d    = parity_q ^ ccff_tail;
                    if (word_left_q == WL_W'(1)) begin
                        state_d = (bit_cnt_q == LAST_BIT) ? S_DONE : S_FETCH;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        // Ready is withheld under abort so a word offered that cycle is not lost.
        cfg.cfg_ready = (state_q == S_FETCH) && !abort;
        chain_en      = (state_q == S_SHIFT);
        ccff_head     = (state_q == S_SHIFT) && shreg_q[0];
        busy          = (state_q == S_FETCH) || (state_q == S_SHIFT);
        done          = (state_q == S_DONE);
        err           = (state_q == S_ERROR);
        tail_parity   = parity_q;
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// ---------------------------------------------------------------------------
// tb_ccff_chain_loader
//   Directed bench for ccff_chain_loader. Two loaders share stimulus: dut_a
//   drives a 32-flop chain model, dut_b a 20-flop chain model (partial final
//   word). sel picks which loader's handshake paces the word feed.
// ---------------------------------------------------------------------------
module tb_ccff_chain_loader;

    logic prog_clk = 1'b0;
    logic pReset;
    logic start;
    logic abort;
    logic sel;

    always #5 prog_clk = ~prog_clk;

    ccff_chain_loader_if #(.WORD_W(8)) if_a ();
    ccff_chain_loader_if #(.WORD_W(8)) if_b ();

    logic a_head, a_tail, a_en, a_busy, a_done, a_err, a_par;
    logic b_head, b_tail, b_en, b_busy, b_done, b_err, b_par;

    ccff_chain_loader #(.CHAIN_LEN(32), .WORD_W(8), .STALL_MAX(16)) dut_a (
        .prog_clk    (prog_clk),
        .pReset      (pReset),
        .start       (start),
        .abort       (abort),
        .cfg         (if_a),
        .ccff_head   (a_head),
        .ccff_tail   (a_tail),
        .chain_en    (a_en),
        .busy        (a_busy),
        .done        (a_done),
        .err         (a_err),
        .tail_parity (a_par)
    );

    ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8), .STALL_MAX(16)) dut_b (
        .prog_clk    (prog_clk),
        .pReset      (pReset),
        .start       (start),
        .abort       (abort),
        .cfg         (if_b),
        .ccff_head   (b_head),
        .ccff_tail   (b_tail),
        .chain_en    (b_en),
        .busy        (b_busy),
        .done        (b_done),
        .err         (b_err),
        .tail_parity (b_par)
    );

    // chain models: bit 0 is the tail end, new bits enter at the top
    logic [31:0] chain_a;
    logic [19:0] chain_b;
    logic [31:0] pre_val;
    logic        pre_req = 1'b0;
    int          en_a = 0, en_b = 0, bursts_a = 0, head_n = 0;
    logic        a_en_d = 1'b0;
    logic [7:0]  head_log = '0;

    assign a_tail = chain_a[0];
    assign b_tail = chain_b[0];

    always @(posedge prog_clk) begin
        if (pre_req) begin
            chain_a  <= pre_val;
            chain_b  <= pre_val[19:0];
            en_a     <= 0;
            en_b     <= 0;
            bursts_a <= 0;
            head_n   <= 0;
            a_en_d   <= 1'b0;
        end else begin
            a_en_d <= a_en;
            if (a_en) begin
                chain_a <= {a_head, chain_a[31:1]};
                en_a    <= en_a + 1;
                if (!a_en_d) bursts_a <= bursts_a + 1;
                if (head_n < 8) begin
                    head_log[head_n] <= a_head;
                    head_n           <= head_n + 1;
                end
            end
            if (b_en) begin
                chain_b <= {b_head, chain_b[19:1]};
                en_b    <= en_b + 1;
            end
        end
    end

    wire cur_ready = sel ? if_b.cfg_ready : if_a.cfg_ready;
    wire cur_done  = sel ? b_done : a_done;
    wire cur_err   = sel ? b_err  : a_err;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] words [4];
    logic       valid_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] d, input logic v);
        if_a.cfg_data  = d;
        if_b.cfg_data  = d;
        if_a.cfg_valid = v;
        if_b.cfg_valid = v;
        valid_q        = v;
    endtask

    task automatic preload(input logic [31:0] v);
        pre_val = v;
        pre_req = 1'b1;
        @(posedge prog_clk); #1;
        pre_req = 1'b0;
    endtask

    task automatic go_idle();
        abort = 1'b1;
        @(posedge prog_clk); #1;
        abort = 1'b0;
    endtask

    // Start a load and feed words with valid always high; optional mid-load
    // start pulse and abort at a given cycle count after the start edge.
    task automatic run_load(input int n_words, input int start_at, input int abort_at,
                            input int max_cyc, output int cyc);
        int idx;
        bit acc;
        idx = 0;
        drive(words[0], 1'b1);
        start = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
        cyc   = 0;
        while (!cur_done && !cur_err && cyc < max_cyc) begin
            acc   = cur_ready && valid_q && !abort;
            start = (cyc == start_at);
            abort = (cyc == abort_at);
            acc   = cur_ready && valid_q;
            @(posedge prog_clk); #1;
            cyc++;
            if (acc) begin
                idx++;
                drive(words[idx % n_words], 1'b1);
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        int n;
        pReset = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        sel    = 1'b0;
        drive(8'h00, 1'b0);
        #1;
        check("reset_outputs", {if_a.cfg_ready, a_en, a_head, a_busy, a_done, a_err, a_par}, 7'b0);
        #20 pReset = 1'b1;
        @(posedge prog_clk); #1;

        // nominal load
        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF; words[3] = 8'h01;
        preload(32'h0);
        run_load(4, -1, -1, 100, cyc);
        check("nom_done_cycle", cyc, 36);
        check("nom_done", a_done, 1);
        check("nom_busy", a_busy, 0);
        check("nom_en_cycles", en_a, 32);
        check("nom_bursts", bursts_a, 4);
        check("nom_head_first8", head_log, 8'hA5);
        check("nom_chain", chain_a, 32'h01FF3CA5);
        check("nom_parity0", a_par, 0);
        repeat (5) @(posedge prog_clk);
        #1;
        check("nom_no_extra_en", en_a, 32);
        check("nom_done_hold", a_done, 1);
        check("nom_ready_low", if_a.cfg_ready, 0);

        // tail parity, with a start pulse mid-load that must be ignored
        preload(32'h0000_0007);
        run_load(4, 3, -1, 100, cyc);
        check("par7_done_cycle", cyc, 36);
        check("par7_parity", a_par, 1);
        check("par7_chain", chain_a, 32'h01FF3CA5);
        preload(32'hFFFF_FFFF);
        run_load(4, -1, -1, 100, cyc);
        check("parF_done", a_done, 1);
        check("parF_parity", a_par, 0);

        // partial final word on the 20-flop chain
        go_idle();
        sel = 1'b1;
        words[0] = 8'h12; words[1] = 8'h34; words[2] = 8'hF6; words[3] = 8'h00;
        preload(32'h0);
        run_load(3, -1, -1, 100, cyc);
        check("part_done", b_done, 1);
        check("part_done_cycle", cyc, 23);
        check("part_en_cycles", en_b, 20);
        check("part_chain", chain_b, 20'h63412);
        sel = 1'b0;
        go_idle();

        // stall timeout
        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF; words[3] = 8'h01;
        preload(32'h0);
        drive(8'hA5, 1'b1);
        start = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
        @(posedge prog_clk); #1;
        drive(8'h00, 1'b0);
        n = 0;
        while (!if_a.cfg_ready && n < 50) begin
            @(posedge prog_clk); #1;
            n++;
        end
        check("stall_refetch", if_a.cfg_ready, 1);
        n = 0;
        while (!a_err && n < 40) begin
            @(posedge prog_clk); #1;
            n++;
        end
        check("stall_err_cycles", n, 16);
        check("stall_err", a_err, 1);
        check("stall_chain_en", a_en, 0);
        check("stall_busy", a_busy, 0);
        check("stall_en_cycles", en_a, 8);
        start = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
        check("stall_restart_err", a_err, 0);
        check("stall_restart_busy", a_busy, 1);
        go_idle();

        // abort during second word; parity of bits already seen is kept
        preload(32'h0000_0007);
        run_load(4, -1, 12, 14, cyc);
        check("abort_en_cycles", en_a, 11);
        check("abort_chain_en", a_en, 0);
        check("abort_busy", a_busy, 0);
        check("abort_done", a_done, 0);
        check("abort_parity_hold", a_par, 1);

        // start and abort together in IDLE
        start = 1'b1;
        abort = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", a_busy, 0);
        check("start_abort_ready", if_a.cfg_ready, 0);

        // asynchronous reset in SHIFT
        preload(32'h0);
        run_load(4, -1, -1, 5, cyc);
        check("rst_pre_shift", a_en, 1);
        #3 pReset = 1'b0;
        #1;
        check("rst_async", {a_en, a_busy, if_a.cfg_ready}, 3'b000);
        @(posedge prog_clk);
        #2 pReset = 1'b1;
        @(posedge prog_clk); #1;
        check("rst_release_outputs", {if_a.cfg_ready, a_en, a_head, a_busy, a_done, a_err, a_par}, 7'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
